// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants and state encoding for the sequential multi-byte adder.
// Optional signed-overflow output is enabled with MULTIBYTE_ADD_OVF_EN.
package multibyte_add_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // Byte index width: clog2(nbytes), never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Start/done handshake and operand/result bus of the multi-byte adder.
// The ovf signal exists only when MULTIBYTE_ADD_OVF_EN is defined.
interface multibyte_add_seq_if #(
    parameter int unsigned NBYTES = 4
);
    import multibyte_add_seq_pkg::*;

    localparam int unsigned W = BYTE_W * NBYTES;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MULTIBYTE_ADD_OVF_EN
    logic         ovf;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout
    );
`endif

endinterface

// File: rtl/multibyte_add_seq_fulladder8b.sv
// Purely combinational 8-bit ripple-carry adder.
module fulladder8b
    import multibyte_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[BYTE_W];
    end

endmodule

// File: rtl/multibyte_add_seq.sv
// Sequential W-bit adder: one byte pair per cycle through a single 8-bit adder, LSB first.
// Define MULTIBYTE_ADD_OVF_EN to add the signed-overflow flag.
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    multibyte_add_seq_if.slave   bus
);

    localparam int unsigned W    = BYTE_W * NBYTES;
    localparam int unsigned IdxW = idx_width(NBYTES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [BYTE_W-1:0] add_a, add_b, add_s;
    logic              add_cout;
    logic              last;

    assign add_a = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
    assign add_b = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
    assign last  = (idx_q == LastIdx);

    fulladder8b u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

`ifdef MULTIBYTE_ADD_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MULTIBYTE_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef MULTIBYTE_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            StRun: begin
                sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = add_s;
                carry_d = add_cout;
                if (last) begin
                    state_d = StDone;
                    cout_d  = add_cout;
`ifdef MULTIBYTE_ADD_OVF_EN
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[BYTE_W-1] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef MULTIBYTE_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Randomised scoreboard bench for multibyte_add_seq (NBYTES=4), with or without MULTIBYTE_ADD_OVF_EN.
module tb_multibyte_add_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic ovf_w;

    multibyte_add_seq_if #(.NBYTES(NB)) bus ();

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef MULTIBYTE_ADD_OVF_EN
    assign ovf_w = bus.ovf;
`else
    assign ovf_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: exact unsigned sum, and signed overflow as a range check on the true value.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] u;
        longint s;
        u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.sum  = u[W-1:0];
        e.cout = u[W];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_sum", 64'(bus.sum), 64'(e.sum));
                chk("result_cout", 64'(bus.cout), 64'(e.cout));
`ifdef MULTIBYTE_ADD_OVF_EN
                chk("result_ovf", 64'(ovf_w), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_sum"},  64'(bus.sum),  64'd0);
        chk({tag, "_cout"}, 64'(bus.cout), 64'd0);
`ifdef MULTIBYTE_ADD_OVF_EN
        chk({tag, "_ovf"},  64'(ovf_w),    64'd0);
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // pulses: re-assert start with fresh operands during RUN and DONE.
    // abort_at: nonzero -> pull reset in that cycle and expect no result.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit pulses, input int abort_at);
        exp_t e;
        e = model(a, b, c);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
        if (abort_at == 0) exp_q.push_back(e);
        for (int k = 1; k <= int'(NB) + 2; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                @(negedge clk);
                bus.start = 1'b0;
                rst_n = 1'b1;
                return;
            end
            chk($sformatf("busy_c%0d", k), 64'(bus.busy), 64'(k >= 1 && k <= int'(NB)));
            chk($sformatf("done_c%0d", k), 64'(bus.done), 64'(k == int'(NB) + 1));
            if (k == 1) chk("sum_cleared", 64'(bus.sum), 64'd0);
            if (k == int'(NB) + 2) begin
                chk("held_sum", 64'(bus.sum), 64'(e.sum));
                chk("held_cout", 64'(bus.cout), 64'(e.cout));
            end
            bus.start = pulses && (k == 2 || k == int'(NB) + 1);
            if (bus.start) begin
                bus.a_in = $urandom();
                bus.b_in = $urandom();
                bus.cin  = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_add(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
        do_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_add(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 0);
        do_add(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, 3);
        do_add(32'h00FF_00FF, 32'hFF01_FF01, 1'b0, 1'b0, 0);
        do_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_add(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom();
            rb = $urandom();
            if (i % 8 == 0) rb = ~ra;
            do_add(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
